// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between fetch and load/store ports with in-order response routing
module mem_bus_arbiter #(
  parameter int MAX_OUTST    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        proto_err
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;
  localparam int PW = MAX_OUTST > 1 ? $clog2(MAX_OUTST) : 1;
  localparam int CW = $clog2(MAX_OUTST) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [1:0]           state_q, state_d;
  logic [MAX_OUTST-1:0] own_q, own_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [SW-1:0]        starve_q, starve_d;
  logic                 proto_err_q, proto_err_d;
  logic                 gnt_i, gnt_d, push, pop, head_d, room;
  assign gnt_i = state_q == GNT_I;
  assign gnt_d = state_q == GNT_D;
  assign push  = (gnt_i | gnt_d) & bus_addr_ok;
  assign pop   = bus_data_ok & (count_q != '0);
  assign head_d = own_q[rd_ptr_q];
  assign room  = count_q < CW'(MAX_OUTST);
  assign bus_req      = gnt_i | gnt_d;
  assign bus_wr       = gnt_d & data_wr;
  assign bus_size     = gnt_d ? data_size : gnt_i ? 2'd2 : 2'd0;
  assign bus_addr     = gnt_d ? data_addr : gnt_i ? inst_addr : 32'd0;
  assign bus_wdata    = gnt_d ? data_wdata : 32'd0;
  assign inst_addr_ok = gnt_i & bus_addr_ok;
  assign data_addr_ok = gnt_d & bus_addr_ok;
  assign inst_data_ok = pop & ~head_d;
  assign data_data_ok = pop & head_d;
  assign inst_rdata   = inst_data_ok ? bus_rdata : 32'd0;
  assign data_rdata   = data_data_ok ? bus_rdata : 32'd0;
  assign proto_err    = proto_err_q;
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE)
      state_d = !room ? IDLE :
                (data_req && (!inst_req || starve_q < SW'(STARVE_LIMIT))) ? GNT_D :
                inst_req ? GNT_I : IDLE;
    else if (bus_addr_ok)
      state_d = IDLE;
    own_d = own_q;
    if (push) own_d[wr_ptr_q] = gnt_d;
    wr_ptr_d = !push ? wr_ptr_q : (wr_ptr_q == PW'(MAX_OUTST - 1)) ? '0 : wr_ptr_q + 1'b1;
    rd_ptr_d = !pop ? rd_ptr_q : (rd_ptr_q == PW'(MAX_OUTST - 1)) ? '0 : rd_ptr_q + 1'b1;
    count_d  = count_q + CW'(push) - CW'(pop);
    // data wins only count toward starvation while fetch is actually waiting
    starve_d = inst_addr_ok ? '0 :
               (data_addr_ok && inst_req && starve_q < SW'(STARVE_LIMIT)) ? starve_q + 1'b1 :
               starve_q;
    proto_err_d = proto_err_q | (bus_data_ok & (count_q == '0));
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      own_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      own_q       <= own_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      proto_err_q <= proto_err_d;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of grant priority, starvation, FIFO routing and protocol errors
module tb_mem_bus_arbiter;
  logic clk = 1'b0, reset = 1'b0;
  logic inst_req = 0, data_req = 0, data_wr = 0, bus_addr_ok = 0, bus_data_ok = 0;
  logic [1:0] data_size = 2'd0;
  logic [31:0] inst_addr = 0, data_addr = 0, data_wdata = 0, bus_rdata = 0;
  logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, bus_req, bus_wr, proto_err;
  logic [31:0] inst_rdata, data_rdata, bus_addr, bus_wdata;
  logic [1:0] bus_size;
  int tests = 0, fails = 0;
  logic [11:0] exp_da = 12'b1000_1010_1010, exp_ia = 12'b0010_0000_0000;
  logic [11:0] exp_dd = 12'b0001_0101_0100, exp_id = 12'b0100_0000_0000;
  mem_bus_arbiter #(.MAX_OUTST(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata), .proto_err(proto_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_inst_addr_ok", inst_addr_ok, 0);
    chk("rst_data_addr_ok", data_addr_ok, 0);
    chk("rst_proto_err", proto_err, 0);
    cyc(); cyc();
    reset = 1;
    data_req = 1; data_wr = 1; data_size = 2'd2; data_addr = 32'h1000_0010; data_wdata = 32'hDEAD_BEEF;
    cyc();
    chk("gd_bus_req", bus_req, 1);
    chk("gd_bus_addr", bus_addr, 32'h1000_0010);
    chk("gd_bus_wr", bus_wr, 1);
    chk("gd_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
    bus_addr_ok = 1; #1;
    chk("gd_data_addr_ok", data_addr_ok, 1);
    cyc();
    bus_addr_ok = 0;
    cyc();
    chk("gd2_bus_req", bus_req, 1);
    reset = 0; #1;
    chk("async_rst_bus_req", bus_req, 0);
    reset = 1; data_req = 0; data_wr = 0;
    cyc();
    bus_data_ok = 1; bus_rdata = 32'h55; #1;
    chk("late_rsp_data_ok", data_data_ok, 0);
    chk("late_rsp_inst_ok", inst_data_ok, 0);
    chk("late_rsp_err_pre", proto_err, 0);
    cyc();
    bus_data_ok = 0; #1;
    chk("late_rsp_err", proto_err, 1);
    reset = 0; #1;
    chk("err_cleared", proto_err, 0);
    reset = 1;
    inst_req = 1; inst_addr = 32'hBFC0_0000; #1;
    chk("f_idle_bus_req", bus_req, 0);
    cyc();
    chk("f_bus_req", bus_req, 1);
    chk("f_bus_addr", bus_addr, 32'hBFC0_0000);
    chk("f_bus_size", bus_size, 2);
    chk("f_bus_wr", bus_wr, 0);
    chk("f_no_ok_yet", inst_addr_ok, 0);
    cyc();
    bus_addr_ok = 1; #1;
    chk("f_addr_ok", inst_addr_ok, 1);
    cyc();
    inst_req = 0; bus_addr_ok = 0; #1;
    chk("f_addr_ok_once", inst_addr_ok, 0);
    chk("f_bus_idle", bus_req, 0);
    cyc(); cyc();
    bus_data_ok = 1; bus_rdata = 32'h3C08_0001; #1;
    chk("f_data_ok", inst_data_ok, 1);
    chk("f_rdata", inst_rdata, 32'h3C08_0001);
    chk("f_no_data_port", data_data_ok, 0);
    chk("f_data_rdata0", data_rdata, 0);
    cyc();
    bus_data_ok = 0;
    inst_req = 1; inst_addr = 32'hBFC0_0004; data_req = 1; data_addr = 32'h8000_1000;
    cyc();
    chk("p_data_first", bus_addr, 32'h8000_1000);
    bus_addr_ok = 1; #1;
    chk("p_data_ok", data_addr_ok, 1);
    chk("p_inst_wait", inst_addr_ok, 0);
    cyc();
    data_req = 0; bus_addr_ok = 0;
    cyc();
    chk("p_inst_next", bus_addr, 32'hBFC0_0004);
    bus_addr_ok = 1; #1;
    chk("p_inst_ok", inst_addr_ok, 1);
    cyc();
    bus_addr_ok = 0; inst_req = 0; data_req = 1; data_addr = 32'h8000_2000; #1;
    chk("full_bus_req0", bus_req, 0);
    cyc();
    chk("full_bus_req1", bus_req, 0);
    bus_data_ok = 1; bus_rdata = 32'h1111_1111; #1;
    chk("full_rsp_data", data_data_ok, 1);
    chk("full_rsp_rdata", data_rdata, 32'h1111_1111);
    chk("full_rsp_inst0", inst_data_ok, 0);
    cyc();
    bus_data_ok = 0; #1;
    chk("full_after_pop", bus_req, 0);
    cyc();
    chk("full_regrant", bus_req, 1);
    chk("full_regrant_addr", bus_addr, 32'h8000_2000);
    bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'h2222_2222; #1;
    chk("col_data_addr_ok", data_addr_ok, 1);
    chk("col_inst_data_ok", inst_data_ok, 1);
    chk("col_inst_rdata", inst_rdata, 32'h2222_2222);
    chk("col_data_data_ok", data_data_ok, 0);
    cyc();
    bus_addr_ok = 0; data_req = 0; bus_rdata = 32'h3333_3333; #1;
    chk("col_next_data_ok", data_data_ok, 1);
    chk("col_next_rdata", data_rdata, 32'h3333_3333);
    chk("col_next_inst0", inst_data_ok, 0);
    chk("col_no_err", proto_err, 0);
    cyc();
    bus_data_ok = 0;
    data_req = 1; inst_req = 1; bus_addr_ok = 1;
    for (int i = 0; i < 12; i++) begin
      bus_data_ok = (i > 0) && (i % 2 == 0);
      bus_rdata = 32'(i);
      #1;
      chk($sformatf("st_data_addr_ok[%0d]", i), data_addr_ok, exp_da[i]);
      chk($sformatf("st_inst_addr_ok[%0d]", i), inst_addr_ok, exp_ia[i]);
      chk($sformatf("st_data_data_ok[%0d]", i), data_data_ok, exp_dd[i]);
      chk($sformatf("st_inst_data_ok[%0d]", i), inst_data_ok, exp_id[i]);
      cyc();
    end
    data_req = 0; inst_req = 0; bus_addr_ok = 0; bus_data_ok = 0;
    chk("end_no_err", proto_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
